// File: rtl/frv_dmem_arbiter.sv
// frv_dmem_arbiter: shares one data-memory bus between two requesters.
// Round-robin selection with a per-request ownership lock. An owner FIFO
// remembers which port issued each accepted request, so that in-order
// responses can be routed back to that port.
module frv_dmem_arbiter #(
    parameter int MAX_OUTSTANDING = 2,  // accepted-but-unanswered limit (1..4)
    parameter int XL              = 31  // data/address MSB
) (
    input  logic          g_clk,
    input  logic          g_reset,

    // Requester 0 (load/store unit)
    input  logic          m0_req,
    input  logic          m0_wen,
    input  logic [3:0]    m0_strb,
    input  logic [XL:0]   m0_addr,
    input  logic [XL:0]   m0_wdata,
    output logic          m0_gnt,
    output logic          m0_recv,
    input  logic          m0_ack,
    output logic [XL:0]   m0_rdata,
    output logic          m0_error,

    // Requester 1 (instruction fetch / debug)
    input  logic          m1_req,
    input  logic          m1_wen,
    input  logic [3:0]    m1_strb,
    input  logic [XL:0]   m1_addr,
    input  logic [XL:0]   m1_wdata,
    output logic          m1_gnt,
    output logic          m1_recv,
    input  logic          m1_ack,
    output logic [XL:0]   m1_rdata,
    output logic          m1_error,

    // Shared data-memory bus
    output logic          dmem_req,
    output logic          dmem_wen,
    output logic [3:0]    dmem_strb,
    output logic [XL:0]   dmem_addr,
    output logic [XL:0]   dmem_wdata,
    input  logic          dmem_gnt,
    input  logic          dmem_recv,
    output logic          dmem_ack,
    input  logic [XL:0]   dmem_rdata,
    input  logic          dmem_error,

    output logic          arb_err
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    // Arbitration state
    logic                       lock;
    logic                       lock_id;
    logic                       last_id;

    // Outstanding-transaction tracking
    logic [CNT_W-1:0]           count;
    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;
    logic [MAX_OUTSTANDING-1:0] owner_fifo;

    // Combinational decode
    logic                       sel;
    logic                       sel_req;
    logic                       can_issue;
    logic                       push;
    logic                       pop;
    logic                       empty;
    logic                       head_id;
    logic                       head_ack;

    // Pointer increment that wraps at MAX_OUTSTANDING, not at 2**PTR_W
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Request side: pick a port, mux its payload onto the bus, form grants
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path can leave it unassigned and infer a latch.
        sel        = 1'b0;
        if (lock) begin
            sel = lock_id;
        end else if (m0_req && m1_req) begin
            sel = ~last_id;
        end else if (m1_req) begin
            sel = 1'b1;
        end

        sel_req    = sel ? m1_req : m0_req;
        can_issue  = (count < MAX_CNT);

        dmem_req   = sel_req && can_issue;
        dmem_wen   = sel ? m1_wen   : m0_wen;
        dmem_strb  = sel ? m1_strb  : m0_strb;
        dmem_addr  = sel ? m1_addr  : m0_addr;
        dmem_wdata = sel ? m1_wdata : m0_wdata;

        push       = dmem_req && dmem_gnt;
        m0_gnt     = push && !sel;
        m1_gnt     = push &&  sel;
    end

    // Response side: route the bus response to the owner at the FIFO head
    always_comb begin
        empty    = (count == '0);
        head_id  = owner_fifo[head];
        head_ack = head_id ? m1_ack : m0_ack;

        // With nothing outstanding an unexpected response is simply swallowed.
        dmem_ack = empty ? dmem_recv : head_ack;
        pop      = dmem_recv && head_ack && !empty;

        m0_recv  = dmem_recv && !empty && !head_id;
        m1_recv  = dmem_recv && !empty &&  head_id;

        m0_rdata = dmem_rdata;
        m1_rdata = dmem_rdata;
        m0_error = dmem_error;
        m1_error = dmem_error;
    end

    // Control state: lock, round-robin history, pointers, count, sticky error
    always_ff @(posedge g_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (g_reset) begin
            lock    <= 1'b0;
            lock_id <= 1'b0;
            last_id <= 1'b1;
            count   <= '0;
            head    <= '0;
            tail    <= '0;
            arb_err <= 1'b0;
        end else begin
            if (push) begin
                last_id <= sel;
                lock    <= 1'b0;
                tail    <= ptr_next(tail);
            end else if (dmem_req) begin
                lock    <= 1'b1;
                lock_id <= sel;
            end

            if (pop) begin
                head <= ptr_next(head);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            if (dmem_recv && empty) begin
                arb_err <= 1'b1;
            end
        end
    end

    // Owner FIFO storage: records which port issued each accepted request
    always_ff @(posedge g_clk) begin
        // NOTE: the storage array is deliberately not reset; entries are only
        // read between head and tail, and the pointers/count are reset.
        if (push) begin
            owner_fifo[tail] <= sel;
        end
    end

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// tb_frv_dmem_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a queue-based transaction model.
module tb_frv_dmem_arbiter;

    localparam int MAX = 2;

    logic        g_clk = 1'b0;
    logic        g_reset;

    logic        req_v   [2];
    logic        wen_v   [2];
    logic [3:0]  strb_v  [2];
    logic [31:0] addr_v  [2];
    logic [31:0] wdata_v [2];
    logic        ack_v   [2];

    logic        m0_gnt, m0_recv, m0_error;
    logic        m1_gnt, m1_recv, m1_error;
    logic [31:0] m0_rdata, m1_rdata;

    logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_ack, dmem_error;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        arb_err;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: ids of accepted-but-unanswered requests, in order
    bit mq[$];
    int held;      // port whose stalled request owns the bus, or -1
    int last;      // port that won the most recent acceptance
    bit err_m;     // sticky protocol-error flag
    bit exp_g [2]; // expected grants in the most recent cycle

    always #5 g_clk = ~g_clk;

    frv_dmem_arbiter #(.MAX_OUTSTANDING(MAX), .XL(31)) dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .m0_req     (req_v[0]),
        .m0_wen     (wen_v[0]),
        .m0_strb    (strb_v[0]),
        .m0_addr    (addr_v[0]),
        .m0_wdata   (wdata_v[0]),
        .m0_gnt     (m0_gnt),
        .m0_recv    (m0_recv),
        .m0_ack     (ack_v[0]),
        .m0_rdata   (m0_rdata),
        .m0_error   (m0_error),
        .m1_req     (req_v[1]),
        .m1_wen     (wen_v[1]),
        .m1_strb    (strb_v[1]),
        .m1_addr    (addr_v[1]),
        .m1_wdata   (wdata_v[1]),
        .m1_gnt     (m1_gnt),
        .m1_recv    (m1_recv),
        .m1_ack     (ack_v[1]),
        .m1_rdata   (m1_rdata),
        .m1_error   (m1_error),
        .dmem_req   (dmem_req),
        .dmem_wen   (dmem_wen),
        .dmem_strb  (dmem_strb),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_recv  (dmem_recv),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .dmem_error (dmem_error),
        .arb_err    (arb_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic new_payload(input int p, input logic [31:0] a);
        wen_v[p]   = 1'($urandom_range(0, 1));
        strb_v[p]  = 4'($urandom);
        addr_v[p]  = a;
        wdata_v[p] = $urandom;
    endtask

    task automatic reset_dut();
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0;
            ack_v[p] = 1'b0;
            new_payload(p, 32'h0);
        end
        dmem_gnt   = 1'b0;
        dmem_recv  = 1'b0;
        dmem_rdata = 32'h0;
        dmem_error = 1'b0;
        g_reset    = 1'b1;
        @(posedge g_clk);
        @(posedge g_clk);
        @(negedge g_clk);
        g_reset = 1'b0;
        mq.delete();
        held  = -1;
        last  = 1;
        err_m = 1'b0;
        exp_g[0] = 1'b0;
        exp_g[1] = 1'b0;
    endtask

    // One clock cycle: compare all outputs against the model, then advance it
    task automatic tick();
        int sel;
        int hid;
        bit dreq;
        bit dack;
        bit was_empty;
        #1;
        if (held >= 0)                 sel = held;
        else if (req_v[0] && req_v[1]) sel = 1 - last;
        else if (req_v[1])             sel = 1;
        else                           sel = 0;

        dreq     = req_v[sel] && (mq.size() < MAX);
        exp_g[0] = dreq && dmem_gnt && (sel == 0);
        exp_g[1] = dreq && dmem_gnt && (sel == 1);

        was_empty = (mq.size() == 0);
        hid       = was_empty ? -1 : int'(mq[0]);
        dack      = was_empty ? dmem_recv : ack_v[hid];

        check("dmem_req", 32'(dmem_req), 32'(dreq));
        check("m0_gnt",   32'(m0_gnt),   32'(exp_g[0]));
        check("m1_gnt",   32'(m1_gnt),   32'(exp_g[1]));
        check("m0_recv",  32'(m0_recv),  32'(dmem_recv && hid == 0));
        check("m1_recv",  32'(m1_recv),  32'(dmem_recv && hid == 1));
        check("dmem_ack", 32'(dmem_ack), 32'(dack));
        check("arb_err",  32'(arb_err),  32'(err_m));
        if (dreq) begin
            check("dmem_addr",  dmem_addr,  addr_v[sel]);
            check("dmem_wdata", dmem_wdata, wdata_v[sel]);
            check("dmem_wen",   32'(dmem_wen),  32'(wen_v[sel]));
            check("dmem_strb",  32'(dmem_strb), 32'(strb_v[sel]));
        end
        if (dmem_recv) begin
            check("m0_rdata", m0_rdata, dmem_rdata);
            check("m1_rdata", m1_rdata, dmem_rdata);
            check("m0_error", 32'(m0_error), 32'(dmem_error));
            check("m1_error", 32'(m1_error), 32'(dmem_error));
        end

        @(posedge g_clk);
        if (dmem_recv && !was_empty && dack) void'(mq.pop_front());
        if (dmem_recv && was_empty) err_m = 1'b1;
        if (dreq && dmem_gnt) begin
            mq.push_back(bit'(sel));
            last = sel;
            held = -1;
        end else if (dreq) begin
            held = sel;
        end
        @(negedge g_clk);
    endtask

    initial begin
        // Reset state
        reset_dut();
        #1;
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_dmem_ack", 32'(dmem_ack), 32'd0);
        check("rst_arb_err",  32'(arb_err),  32'd0);
        tick();

        // Single requester, zero-latency grant
        req_v[0] = 1'b1;
        new_payload(0, 32'h0000_0100);
        dmem_gnt = 1'b1;
        #1 check("t1_gnt", 32'(m0_gnt), 32'd1);
        tick();
        req_v[0] = 1'b0;
        dmem_gnt = 1'b0;
        tick();

        // Both ports requesting every cycle: grants alternate starting with 0
        reset_dut();
        req_v[0] = 1'b1;
        req_v[1] = 1'b1;
        ack_v[0] = 1'b1;
        ack_v[1] = 1'b1;
        dmem_gnt = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dmem_recv  = (i > 0);
            dmem_rdata = $urandom;
            new_payload(0, 32'h1000 + 32'(i));
            new_payload(1, 32'h2000 + 32'(i));
            #1;
            check("t2_gnt0", 32'(m0_gnt), 32'(i % 2 == 0));
            check("t2_gnt1", 32'(m1_gnt), 32'(i % 2 == 1));
            tick();
        end
        req_v[0] = 1'b0;
        req_v[1] = 1'b0;
        dmem_gnt = 1'b0;
        tick();
        dmem_recv = 1'b0;
        tick();

        // Lock: port 1 stalled for three cycles keeps the bus over port 0
        reset_dut();
        req_v[1] = 1'b1;
        new_payload(1, 32'h0000_1111);
        new_payload(0, 32'h0000_2222);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) req_v[0] = 1'b1;
            if (i == 3) dmem_gnt = 1'b1;
            if (i == 4) req_v[1] = 1'b0;
            #1;
            check("t3_addr", dmem_addr, (i < 4) ? 32'h0000_1111 : 32'h0000_2222);
            check("t3_gnt1", 32'(m1_gnt), 32'(i == 3));
            check("t3_gnt0", 32'(m0_gnt), 32'(i == 4));
            tick();
        end
        req_v[0] = 1'b0;
        dmem_gnt = 1'b0;
        tick();

        // Outstanding limit: two accepts fill it, a pop frees a slot next cycle
        reset_dut();
        req_v[0] = 1'b1;
        ack_v[0] = 1'b1;
        dmem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            new_payload(0, 32'h3000 + 32'(i));
            dmem_recv = (i == 3);
            #1 check("t4_req", 32'(dmem_req), 32'(i < 2 || i == 4));
            if (i == 4) req_v[0] = 1'b0;
            tick();
        end
        req_v[0]  = 1'b0;
        dmem_recv = 1'b1;
        tick();
        tick();
        dmem_recv = 1'b0;
        tick();

        // In-order response routing with distinct read data
        reset_dut();
        ack_v[0] = 1'b1;
        ack_v[1] = 1'b1;
        dmem_gnt = 1'b1;
        req_v[0] = 1'b1;
        tick();
        req_v[0] = 1'b0;
        req_v[1] = 1'b1;
        tick();
        req_v[1]   = 1'b0;
        dmem_gnt   = 1'b0;
        dmem_recv  = 1'b1;
        dmem_rdata = 32'hA5A5_A5A5;
        #1;
        check("t5_recv0_a", 32'(m0_recv), 32'd1);
        check("t5_recv1_a", 32'(m1_recv), 32'd0);
        check("t5_rdata0",  m0_rdata, 32'hA5A5_A5A5);
        tick();
        dmem_rdata = 32'h5A5A_5A5A;
        #1;
        check("t5_recv0_b", 32'(m0_recv), 32'd0);
        check("t5_recv1_b", 32'(m1_recv), 32'd1);
        check("t5_rdata1",  m1_rdata, 32'h5A5A_5A5A);
        tick();
        dmem_recv = 1'b0;
        tick();

        // Response with nothing outstanding: dropped, sticky error until reset
        reset_dut();
        dmem_recv = 1'b1;
        #1;
        check("t6_ack",   32'(dmem_ack), 32'd1);
        check("t6_recv0", 32'(m0_recv),  32'd0);
        check("t6_recv1", 32'(m1_recv),  32'd0);
        tick();
        dmem_recv = 1'b0;
        #1 check("t6_err_set", 32'(arb_err), 32'd1);
        tick();
        tick();
        #1 check("t6_err_hold", 32'(arb_err), 32'd1);
        reset_dut();
        #1 check("t6_err_clr", 32'(arb_err), 32'd0);
        tick();

        // Randomized traffic with occasional mid-transaction resets
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (exp_g[p] || !req_v[p]) begin
                    req_v[p] = ($urandom_range(0, 3) != 0);
                    new_payload(p, $urandom);
                end
                ack_v[p] = ($urandom_range(0, 3) != 0);
            end
            dmem_gnt   = ($urandom_range(0, 2) != 0);
            dmem_recv  = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            dmem_rdata = $urandom;
            dmem_error = ($urandom_range(0, 7) == 0);
            if (c % 700 == 699) reset_dut();
            else                tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
